alu_mc: RTL and testbench
=========================

ALU_MC -- requirements
Module: alu_mc

Interface
REQ-001 SHALL have parameter WIDTH, default 16, data width; power of two, at least 4.
REQ-002 SHALL derive localparam SHW = clog2(WIDTH), shift-amount width.
REQ-003 SHALL have port clk  in  1  sole clock; all state on rising edge.
REQ-004 SHALL have port rst_n  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have port start  in  1  request; accepted when busy=0.
REQ-006 SHALL have port op  in  3  0 AND, 1 OR, 2 ADD, 3 SLT, 4 SLL, 5 SRL, 6 SRA, 7 MUL.
REQ-007 SHALL have port inv  in  1  for AND/OR/ADD, B replaced by ~B; ADD then uses carry-in 1 (SUB); ignored for other ops.
REQ-008 SHALL have port A  in  WIDTH  operand A.
REQ-009 SHALL have port B  in  WIDTH  operand B; shifts use B[SHW-1:0].
REQ-010 SHALL have port busy  out  1  operation in progress; start ignored.
REQ-011 SHALL have port done  out  1  one-cycle pulse when results update.
REQ-012 SHALL have port R  out  WIDTH  registered result.
REQ-013 SHALL have port cout  out  1  ADD/SUB carry-out; 0 for other ops.
REQ-014 SHALL have port ovfl  out  1  ADD/SUB signed overflow; MUL unsigned product exceeds WIDTH bits; 0 for other ops.
REQ-015 SHALL have port zero  out  1  1 when the new R is all zeros.

Function
REQ-016 SHALL implement states IDLE, BUSY, DONE; busy=1 only in BUSY; done=1 only in DONE.
REQ-017 SHALL latch A, B, op, inv on every edge where start=1 and state is IDLE or DONE.
REQ-018 SHALL complete ops 0-3, and shifts with amount 0, at the accepting edge: state goes to DONE, done=1 in the next cycle (latency 1).
REQ-019 SHALL compute SLT as signed A<B, giving R=1 or 0, overflow-correct.
REQ-020 SHALL perform shifts with amount n>0 one bit per cycle in BUSY; done asserts n+1 cycles after acceptance; SRA replicates the MSB.
REQ-021 SHALL perform MUL as shift-add, one partial product per cycle, for WIDTH cycles in BUSY; done asserts WIDTH+1 cycles after acceptance; R is the low WIDTH bits.
REQ-022 SHALL update R, cout, ovfl and zero only on the edge entering DONE, and hold them otherwise, including throughout BUSY.
REQ-023 SHALL go from DONE to IDLE next cycle unless start is accepted; a start in DONE is accepted, allowing back-to-back one-cycle ops every cycle.
REQ-024 SHALL ignore start while in BUSY, with no queuing.
REQ-025 SHALL use an iteration counter of SHW+1 bits with no wrap-around.

Reset
REQ-026 SHALL, when rst_n=0, immediately force state=IDLE, R=0, cout=0, ovfl=0, zero=0, done=0, busy=0, working registers=0.
REQ-027 SHALL abort any operation when reset is asserted mid-operation; no done for the aborted operation.
REQ-028 SHALL accept start on the first clk edge after rst_n deasserts.

Structure
REQ-029 SHALL take op encodings and the state encoding from shared package alu_pkg.
REQ-030 SHALL put single-cycle AND/OR/ADD/SUB/SLT logic, with cout/ovfl, in sub-module alu_core (combinational, WIDTH-parametrised); sequencing, shifter and multiplier stay in alu_mc.

Verification
REQ-031 SHALL check, with WIDTH=16: ADD A=FFFF B=0001 -> next cycle done=1, R=0000, cout=1, ovfl=0, zero=1; ADD A=7FFF B=0001 -> R=8000, ovfl=1, zero=0.
REQ-032 SHALL check SUB (op 2, inv=1) A=0005 B=0007 -> R=FFFE, cout=0, ovfl=0; AND inv=1 A=FFFF B=0001 -> R=FFFE.
REQ-033 SHALL check SLT A=FFFF B=0001 -> R=0001; A=0001 B=FFFF -> R=0000, zero=1.
REQ-034 SHALL check SRA A=8000 B=0004 -> busy for 4 cycles, done 5 cycles after accept, R=F800; SLL A=1234 B=0000 -> done next cycle, R=1234.
REQ-035 SHALL check MUL A=0003 B=0005 -> done 17 cycles after accept, R=000F; MUL A=0100 B=0100 -> R=0000, ovfl=1, zero=1; a start pulsed mid-MUL is ignored.
REQ-036 SHALL check rst_n dropped on the 8th cycle of a MUL -> all outputs 0 at once, no done; a new ADD after release completes normally.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared encodings for the multi-cycle ALU: opcodes, sequencer states, op-class helpers.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package alu_pkg;

    typedef enum logic [2:0] {
        OP_AND = 3'd0,
        OP_OR  = 3'd1,
        OP_ADD = 3'd2,
        OP_SLT = 3'd3,
        OP_SLL = 3'd4,
        OP_SRL = 3'd5,
        OP_SRA = 3'd6,
        OP_MUL = 3'd7
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Ops whose result is produced by the combinational core at the accepting edge.
    function automatic logic is_single(op_e op);
        return (op == OP_AND) || (op == OP_OR) || (op == OP_ADD) || (op == OP_SLT);
    endfunction

    // Ops handled by the one-bit-per-cycle shifter.
    function automatic logic is_shift(op_e op);
        return (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA);
    endfunction

endpackage

// File: rtl/alu_core.sv
// Combinational AND/OR/ADD/SUB/SLT datapath with carry-out and signed overflow.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; outputs follow inputs.
module alu_core
    import alu_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  op_e              op,
    input  logic             inv,
    output logic [WIDTH-1:0] r,
    output logic             cout,
    output logic             ovfl
);

    logic [WIDTH-1:0] b_eff;
    logic             cin;
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   diff;

    // Operand conditioning: inverted B for AND/OR/ADD, carry-in 1 turns ADD into SUB.
    always_comb begin
        b_eff = b;
        cin   = 1'b0;
        if (inv && (op == OP_AND || op == OP_OR || op == OP_ADD)) begin
            b_eff = ~b;
        end
        if (inv && op == OP_ADD) begin
            cin = 1'b1;
        end
    end

    // Adder plus a sign-extended subtractor; the extra bit keeps SLT correct on overflow.
    always_comb begin
        sum  = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, cin};
        diff = {a[WIDTH-1], a} - {b[WIDTH-1], b};
    end

    // Result select; carry and overflow are only meaningful for ADD/SUB.
    always_comb begin
        r    = '0;
        cout = 1'b0;
        ovfl = 1'b0;
        case (op)
            OP_AND: r = a & b_eff;
            OP_OR:  r = a | b_eff;
            OP_ADD: begin
                r    = sum[WIDTH-1:0];
                cout = sum[WIDTH];
                ovfl = (a[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SLT: r = {{(WIDTH-1){1'b0}}, diff[WIDTH]};
            default: begin
                r    = '0;
                cout = 1'b0;
                ovfl = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU: 1-cycle logic/arith ops, bit-serial shifts, shift-add multiply.
// Latency: 1 cycle for AND/OR/ADD/SLT and zero shifts, n+1 for shift by n, WIDTH+1 for MUL.
// Backpressure: busy=1 while iterating; start is dropped (not queued) during busy.
module alu_mc
    import alu_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic             inv,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] R,
    output logic             cout,
    output logic             ovfl,
    output logic             zero
);

    localparam int             SHW     = $clog2(WIDTH);
    localparam int             CW      = SHW + 1;
    localparam logic [CW-1:0]  CNT_MUL = CW'(WIDTH);
    localparam logic [CW-1:0]  CNT_ONE = CW'(1);

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   opa_q, opa_d;
    logic [WIDTH-1:0]   opb_q, opb_d;
    op_e                op_q, op_d;
    logic               inv_q, inv_d;
    logic [2*WIDTH-1:0] wk_q, wk_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [WIDTH-1:0]   r_q, r_d;
    logic               cout_q, cout_d;
    logic               ovfl_q, ovfl_d;
    logic               zero_q, zero_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic               accept;
    op_e                op_in;
    logic [SHW-1:0]     sh_amt;
    logic [WIDTH-1:0]   core_a, core_b;
    op_e                core_op;
    logic               core_inv;
    logic [WIDTH-1:0]   core_r;
    logic               core_cout, core_ovfl;
    logic [WIDTH-1:0]   shifted;
    logic [WIDTH:0]     hi_sum;
    logic [2*WIDTH-1:0] mul_next;

    // Request decode; the core sees live operands while accepting, held ones otherwise.
    always_comb begin
        accept   = start && (state_q != ST_BUSY);
        op_in    = op_e'(op);
        sh_amt   = B[SHW-1:0];
        core_a   = accept ? A     : opa_q;
        core_b   = accept ? B     : opb_q;
        core_op  = accept ? op_in : op_q;
        core_inv = accept ? inv   : inv_q;
    end

    alu_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .a    (core_a),
        .b    (core_b),
        .op   (core_op),
        .inv  (core_inv),
        .r    (core_r),
        .cout (core_cout),
        .ovfl (core_ovfl)
    );

    // One-bit shift step on the low half of the working register.
    always_comb begin
        case (op_q)
            OP_SLL:  shifted = {wk_q[WIDTH-2:0], 1'b0};
            OP_SRL:  shifted = {1'b0, wk_q[WIDTH-1:1]};
            OP_SRA:  shifted = {wk_q[WIDTH-1], wk_q[WIDTH-1:1]};
            default: shifted = wk_q[WIDTH-1:0];
        endcase
    end

    // Shift-add multiply step: add A into the high half when the current multiplier bit
    // is set, then shift the {carry, high, low} product right by one.
    always_comb begin
        hi_sum   = {1'b0, wk_q[2*WIDTH-1:WIDTH]} + (opb_q[0] ? {1'b0, opa_q} : '0);
        mul_next = {hi_sum, wk_q[WIDTH-1:1]};
    end

    // Sequencer next-state and result update; results change only when entering DONE.
    always_comb begin
        state_d = state_q;
        opa_d   = opa_q;
        opb_d   = opb_q;
        op_d    = op_q;
        inv_d   = inv_q;
        wk_d    = wk_q;
        cnt_d   = cnt_q;
        r_d     = r_q;
        cout_d  = cout_q;
        ovfl_d  = ovfl_q;
        zero_d  = zero_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (accept) begin
                    opa_d = A;
                    opb_d = B;
                    op_d  = op_in;
                    inv_d = inv;
                    if (is_single(op_in)) begin
                        state_d = ST_DONE;
                        r_d     = core_r;
                        cout_d  = core_cout;
                        ovfl_d  = core_ovfl;
                        zero_d  = (core_r == '0);
                    end else if (is_shift(op_in) && sh_amt == '0) begin
                        state_d = ST_DONE;
                        r_d     = A;
                        cout_d  = 1'b0;
                        ovfl_d  = 1'b0;
                        zero_d  = (A == '0);
                    end else if (is_shift(op_in)) begin
                        state_d = ST_BUSY;
                        wk_d    = {{WIDTH{1'b0}}, A};
                        cnt_d   = {1'b0, sh_amt};
                    end else begin
                        state_d = ST_BUSY;
                        wk_d    = '0;
                        cnt_d   = CNT_MUL;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_BUSY: begin
                cnt_d = cnt_q - CNT_ONE;
                if (op_q == OP_MUL) begin
                    opb_d = {1'b0, opb_q[WIDTH-1:1]};
                    wk_d  = mul_next;
                    if (cnt_q == CNT_ONE) begin
                        state_d = ST_DONE;
                        r_d     = mul_next[WIDTH-1:0];
                        cout_d  = 1'b0;
                        ovfl_d  = |mul_next[2*WIDTH-1:WIDTH];
                        zero_d  = (mul_next[WIDTH-1:0] == '0);
                    end
                end else begin
                    wk_d = {wk_q[2*WIDTH-1:WIDTH], shifted};
                    if (cnt_q == CNT_ONE) begin
                        state_d = ST_DONE;
                        r_d     = shifted;
                        cout_d  = 1'b0;
                        ovfl_d  = 1'b0;
                        zero_d  = (shifted == '0);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
        busy_d = (state_d == ST_BUSY);
        done_d = (state_d == ST_DONE);
    end

    // State, working and result registers; reset aborts any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            opa_q   <= '0;
            opb_q   <= '0;
            op_q    <= OP_AND;
            inv_q   <= 1'b0;
            wk_q    <= '0;
            cnt_q   <= '0;
            r_q     <= '0;
            cout_q  <= 1'b0;
            ovfl_q  <= 1'b0;
            zero_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            op_q    <= op_d;
            inv_q   <= inv_d;
            wk_q    <= wk_d;
            cnt_q   <= cnt_d;
            r_q     <= r_d;
            cout_q  <= cout_d;
            ovfl_q  <= ovfl_d;
            zero_q  <= zero_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign R    = r_q;
    assign cout = cout_q;
    assign ovfl = ovfl_q;
    assign zero = zero_q;

endmodule

// File: tb/tb_alu_mc.sv
// Self-checking bench for alu_mc (WIDTH=16): behavioural model plus literal spot checks.
// Latency: model predicts done/busy per cycle from op latency rules.
// Backpressure: random starts land while busy and must be dropped.
module tb_alu_mc;

    localparam int W = 16;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b1;
    logic          start = 1'b0;
    logic [2:0]    op    = 3'd0;
    logic          inv   = 1'b0;
    logic [W-1:0]  A     = '0;
    logic [W-1:0]  B     = '0;
    logic          busy, done, cout, ovfl, zero;
    logic [W-1:0]  R;

    int n_checks = 0;
    int n_errs   = 0;

    alu_mc #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .op    (op),
        .inv   (inv),
        .A     (A),
        .B     (B),
        .busy  (busy),
        .done  (done),
        .R     (R),
        .cout  (cout),
        .ovfl  (ovfl),
        .zero  (zero)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        logic [W-1:0] r;
        logic         c;
        logic         o;
        int           lat;
    } res_t;

    function automatic res_t ref_op(input logic [2:0] o, input logic iv,
                                    input logic [W-1:0] a, input logic [W-1:0] b);
        res_t         x;
        int           n, sa, sb, s;
        longint       p;
        logic [W-1:0] nb;
        x.r = '0; x.c = 1'b0; x.o = 1'b0; x.lat = 1;
        n  = int'(b[3:0]);
        sa = $signed(a);
        sb = $signed(b);
        nb = ~b;
        case (o)
            3'd0: x.r = iv ? (a & nb) : (a & b);
            3'd1: x.r = iv ? (a | nb) : (a | b);
            3'd2: begin
                if (iv) begin
                    p = longint'(a) + longint'(nb) + 1;
                    s = sa - sb;
                end else begin
                    p = longint'(a) + longint'(b);
                    s = sa + sb;
                end
                x.r = p[W-1:0];
                x.c = p[W];
                x.o = (s > 32767) || (s < -32768);
            end
            3'd3: x.r = (sa < sb) ? 16'd1 : 16'd0;
            3'd4: begin x.r = a << n; x.lat = n + 1; end
            3'd5: begin x.r = a >> n; x.lat = n + 1; end
            3'd6: begin x.r = 16'(sa >>> n); x.lat = n + 1; end
            default: begin
                p     = longint'(a) * longint'(b);
                x.r   = p[W-1:0];
                x.o   = (p > 65535);
                x.lat = W + 1;
            end
        endcase
        return x;
    endfunction

    int           m_rem  = 0;
    logic         m_done = 1'b0;
    logic [W-1:0] m_r    = '0;
    logic         m_c    = 1'b0;
    logic         m_o    = 1'b0;
    logic         m_z    = 1'b0;
    res_t         m_pend;
    res_t         m_new;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_rem = 0; m_done = 1'b0; m_r = '0; m_c = 1'b0; m_o = 1'b0; m_z = 1'b0;
        end else if (m_rem > 0) begin
            m_rem  = m_rem - 1;
            m_done = 1'b0;
            if (m_rem == 0) begin
                m_r = m_pend.r; m_c = m_pend.c; m_o = m_pend.o; m_z = (m_pend.r == '0);
                m_done = 1'b1;
            end
        end else begin
            m_done = 1'b0;
            if (start) begin
                m_new = ref_op(op, inv, A, B);
                if (m_new.lat == 1) begin
                    m_r = m_new.r; m_c = m_new.c; m_o = m_new.o; m_z = (m_new.r == '0);
                    m_done = 1'b1;
                end else begin
                    m_pend = m_new;
                    m_rem  = m_new.lat - 1;
                end
            end
        end
    end

    // Cycle-by-cycle comparison of every output against the model.
    always @(negedge clk) begin
        chk("cycle{busy,done,R,cout,ovfl,zero}",
            {11'd0, busy, done, R, cout, ovfl, zero},
            {11'd0, (m_rem > 0), m_done, m_r, m_c, m_o, m_z});
    end

    // ---------------- directed operation with literal expectations ----------------
    task automatic do_op(input string name, input logic [2:0] o, input logic iv,
                         input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] er, input logic ec, input logic eo, input logic ez,
                         input int elat, input int ebusy, input int mid);
        int k;
        int nb;
        bit got;
        @(posedge clk); #2;
        start = 1'b1; op = o; inv = iv; A = a; B = b;
        @(posedge clk); #2;
        start = 1'b0; A = 16'($urandom); B = 16'($urandom); inv = 1'($urandom);
        k = 0; nb = 0; got = 1'b0;
        while (!got && k < 100) begin
            @(negedge clk);
            k++;
            if (busy) nb++;
            if (done) begin
                got = 1'b1;
            end else if (mid > 0 && k == mid) begin
                #1;
                start = 1'b1; op = 3'd2; A = 16'h0001; B = 16'h0001;
            end else begin
                start = 1'b0;
            end
        end
        start = 1'b0;
        chk({name, "_latency"}, k, elat);
        chk({name, "_busy_cycles"}, nb, ebusy);
        chk({name, "_R"}, R, er);
        chk({name, "_cout"}, cout, ec);
        chk({name, "_ovfl"}, ovfl, eo);
        chk({name, "_zero"}, zero, ez);
    endtask

    initial begin
        int nd;
        logic [W-1:0] corner [5];
        corner[0] = 16'h0000; corner[1] = 16'hFFFF; corner[2] = 16'h8000;
        corner[3] = 16'h7FFF; corner[4] = 16'h0001;

        // Reset state
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_R", R, 0);
        chk("reset_flags", {cout, ovfl, zero}, 0);
        @(posedge clk); #3 rst_n = 1'b1;

        // Single-cycle ops
        do_op("add_ffff_1", 3'd2, 0, 16'hFFFF, 16'h0001, 16'h0000, 1, 0, 1, 1, 0, 0);
        do_op("add_7fff_1", 3'd2, 0, 16'h7FFF, 16'h0001, 16'h8000, 0, 1, 0, 1, 0, 0);
        do_op("sub_5_7",    3'd2, 1, 16'h0005, 16'h0007, 16'hFFFE, 0, 0, 0, 1, 0, 0);
        do_op("andn_ffff",  3'd0, 1, 16'hFFFF, 16'h0001, 16'hFFFE, 0, 0, 0, 1, 0, 0);
        do_op("slt_m1_1",   3'd3, 0, 16'hFFFF, 16'h0001, 16'h0001, 0, 0, 0, 1, 0, 0);
        do_op("slt_1_m1",   3'd3, 0, 16'h0001, 16'hFFFF, 16'h0000, 0, 0, 1, 1, 0, 0);
        // Shifts
        do_op("sra_8000_4", 3'd6, 0, 16'h8000, 16'h0004, 16'hF800, 0, 0, 0, 5, 4, 0);
        do_op("sll_1234_0", 3'd4, 0, 16'h1234, 16'h0000, 16'h1234, 0, 0, 0, 1, 0, 0);
        // Multiply, with a start pulsed in the middle that must be dropped
        do_op("mul_3_5",    3'd7, 0, 16'h0003, 16'h0005, 16'h000F, 0, 0, 0, 17, 16, 6);
        do_op("mul_100_100",3'd7, 0, 16'h0100, 16'h0100, 16'h0000, 0, 1, 1, 17, 16, 0);
        do_op("add_1_1",    3'd2, 0, 16'h0001, 16'h0001, 16'h0002, 0, 0, 0, 1, 0, 0);

        // Reset in the 8th cycle of a MUL
        @(posedge clk); #2;
        start = 1'b1; op = 3'd7; inv = 1'b0; A = 16'h0003; B = 16'h0005;
        @(posedge clk); #2;
        start = 1'b0;
        repeat (7) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_R", R, 0);
        chk("abort_flags", {cout, ovfl, zero}, 0);
        repeat (2) @(negedge clk);
        start = 1'b1; op = 3'd2; inv = 1'b0; A = 16'h1234; B = 16'h0001;
        @(posedge clk); #3 rst_n = 1'b1;
        @(posedge clk); #2 start = 1'b0;
        @(negedge clk);
        chk("post_reset_add_done", done, 1);
        chk("post_reset_add_R", R, 16'h1235);
        nd = 0;
        repeat (25) begin
            @(negedge clk);
            if (done) nd++;
        end
        chk("aborted_mul_no_done", nd, 0);

        // Randomized traffic, including starts while busy and back-to-back ops
        repeat (1500) begin
            @(posedge clk); #2;
            start = ($urandom_range(0, 2) != 0);
            op    = 3'($urandom);
            inv   = 1'($urandom);
            A     = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 4)] : 16'($urandom);
            B     = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 4)] : 16'($urandom);
        end
        @(posedge clk); #2 start = 1'b0;
        repeat (20) @(posedge clk);
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
